// File: rtl/mem_stage.sv
// LA32R MEM stage: waits for the data-bus response of an issued load/store, extracts
// and extends load data, forwards results to WB and ID, and drops responses of flushed requests.
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ws_allowin,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [194:0] es_to_ms_bus,
    input  logic         es_to_ms_req,
    input  logic         es_req_inflight,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    output logic         ms_to_ws_valid,
    output logic [194:0] ms_to_ws_bus,
    output logic [39:0]  ms_to_ds_bus,
    output logic         ms_ex,
    input  logic         ws_flush
);

    logic         ms_valid_q, ms_valid_d;
    logic [194:0] bus_q, bus_d;
    logic         req_q, req_d;
    logic         buf_valid_q, buf_valid_d;
    logic [31:0]  buf_data_q, buf_data_d;
    logic [1:0]   cancel_cnt_q, cancel_cnt_d;

    logic        res_from_mem, gr_we, mem_sign, adef, ine, sys, ale, csr_re, csr_we;
    logic        ertn, res_from_csr, brk;
    logic [4:0]  dest;
    logic [31:0] alu_result, mem_addr;
    logic [1:0]  mem_size, rdcnt_detail;

    assign res_from_mem = bus_q[194];
    assign gr_we        = bus_q[193];
    assign dest         = bus_q[192:188];
    assign alu_result   = bus_q[187:156];
    assign mem_size     = bus_q[123:122];
    assign mem_sign     = bus_q[121];
    assign adef         = bus_q[120];
    assign ine          = bus_q[119];
    assign sys          = bus_q[118];
    assign ale          = bus_q[117];
    assign csr_re       = bus_q[116];
    assign csr_we       = bus_q[115];
    assign ertn         = bus_q[36];
    assign res_from_csr = bus_q[35];
    assign brk          = bus_q[34];
    assign rdcnt_detail = bus_q[33:32];
    assign mem_addr     = bus_q[31:0];

    logic        wait_st, data_ok_live, ms_ready_go, reg_able;
    logic [31:0] word, load_val, final_result;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [2:0]  cnt_sum;

    assign wait_st        = ms_valid_q & req_q & ~buf_valid_q;
    assign data_ok_live   = data_sram_data_ok & (cancel_cnt_q == 2'd0);
    assign ms_ready_go    = ~req_q | buf_valid_q | data_ok_live;
    assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
    assign ms_ex          = ms_valid_q & (adef | ine | sys | ale | brk | ertn);

    always_comb begin
        word     = buf_valid_q ? buf_data_q : data_sram_rdata;
        byte_sel = word[7:0];
        half_sel = mem_addr[1] ? word[31:16] : word[15:0];
        unique case (mem_addr[1:0])
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        case (mem_size)
            2'b01:   load_val = {{24{mem_sign & byte_sel[7]}}, byte_sel};
            2'b10:   load_val = {{16{mem_sign & half_sel[15]}}, half_sel};
            default: load_val = word;
        endcase
        final_result = res_from_mem ? load_val : alu_result;
    end

    assign reg_able = ~(ms_valid_q & (res_from_csr | (rdcnt_detail != 2'd0) |
                                      (res_from_mem & ~ms_ready_go)));

    assign ms_to_ws_bus = {bus_q[194:188], final_result, bus_q[155:0]};
    assign ms_to_ds_bus = {reg_able, dest & {5{ms_valid_q & gr_we}}, final_result,
                           csr_we & ms_valid_q, (csr_re | csr_we) & ms_valid_q};

    always_comb begin
        ms_valid_d  = ms_valid_q;
        bus_d       = bus_q;
        req_d       = req_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (ws_flush) begin
            ms_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
            req_d       = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d  = es_to_ms_valid;
            buf_valid_d = 1'b0;
            req_d       = es_to_ms_valid & es_to_ms_req;
            if (es_to_ms_valid) begin
                bus_d = es_to_ms_bus;
            end
        end else if (wait_st & data_ok_live) begin
            // Response arrived while WB stalls: hold it so rdata may change underneath.
            buf_valid_d = 1'b1;
            buf_data_d  = data_sram_rdata;
        end

        // A live response consumed in the flush cycle needs no cancel slot.
        cnt_sum = {1'b0, cancel_cnt_q}
                - {2'b0, data_sram_data_ok & (cancel_cnt_q != 2'd0)}
                + {2'b0, ws_flush & wait_st & ~data_ok_live}
                + {2'b0, ws_flush & es_req_inflight};
        cancel_cnt_d = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q   <= 1'b0;
            bus_q        <= '0;
            req_q        <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_data_q   <= '0;
            cancel_cnt_q <= 2'd0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            bus_q        <= bus_d;
            req_q        <= req_d;
            buf_valid_q  <= buf_valid_d;
            buf_data_q   <= buf_data_d;
            cancel_cnt_q <= cancel_cnt_d;
        end
    end

endmodule
